alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu.sv | 70 +++++++
 tb/tb_alu.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// 32-bit RV32 ALU with registered result and branch-compare flag.
// Optional CSR ops (codes 1001-1011) enabled by defining ALU_CSR_OPS_EN.
module alu (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  ALUctl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] ALUOut,
  output logic        Branch_Enable
);

  logic [31:0] res;
  logic        br;
  logic        lt_s;
  logic        lt_u;
  logic        eq;
  logic [4:0]  shamt;

  assign lt_s  = $signed(A) < $signed(B);
  assign lt_u  = A < B;
  assign eq    = A == B;
  assign shamt = B[4:0];

  always_comb begin
    res = '0;
    unique case (ALUctl[3:0])
      4'b0000: res = A & B;
      4'b0001: res = A | B;
      4'b0010: res = A + B;
      4'b0110: res = A - B;
      4'b1000: res = A ^ B;
      4'b0100: res = A << shamt;
      4'b0011: res = A >> shamt;
      4'b0101: res = 32'($signed(A) >>> shamt);
      4'b0111: res = {31'd0, lt_s};
      4'b1100: res = {31'd0, lt_u};
`ifdef ALU_CSR_OPS_EN
      4'b1001: res = A;
      4'b1010: res = A | B;
      4'b1011: res = (~A) & B;
`endif
      default: res = '0;
    endcase
  end

  always_comb begin
    br = 1'b0;
    unique case (ALUctl[6:4])
      3'b001:  br = eq;
      3'b010:  br = ~eq;
      3'b011:  br = lt_s;
      3'b100:  br = ~lt_s;
      3'b101:  br = lt_u;
      3'b110:  br = ~lt_u;
      default: br = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ALUOut        <= '0;
      Branch_Enable <= 1'b0;
    end else begin
      ALUOut        <= res;
      Branch_Enable <= br;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Scoreboard testbench for alu: expectations queued at drive time,
// popped and compared one edge later.
module tb_alu;

  logic        clk;
  logic        reset;
  logic [6:0]  ALUctl;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] ALUOut;
  logic        Branch_Enable;

  typedef struct {
    logic [31:0] out;
    logic        br;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   total;
  int   passed;

  alu dut (
    .clk          (clk),
    .reset        (reset),
    .ALUctl       (ALUctl),
    .A            (A),
    .B            (B),
    .ALUOut       (ALUOut),
    .Branch_Enable(Branch_Enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one op at negedge, queue its expectation, wait past the capture edge.
  task automatic drive(input logic [6:0] ctl, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eo,
                       input logic eb, input string nm);
    exp_t e;
    @(negedge clk);
    ALUctl = ctl;
    A      = a;
    B      = b;
    e.out  = eo;
    e.br   = eb;
    e.name = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_out(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa;
    int n;
    n  = int'(b[4:0]);
    sa = {{32{a[31]}}, a};
    case (op)
      4'h0: return a & b;
      4'h1: return a | b;
      4'h2: return a + b;
      4'h6: return a + (~b) + 32'd1;
      4'h8: return a ^ b;
      4'h4: return a * (32'd1 << n);
      4'h3: return a / (32'd1 << n);
      4'h5: return sa[n +: 32];
      4'h7: return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
      4'hC: return {31'd0, a < b};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_br(input logic [2:0] op,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
    logic slt;
    slt = (a[31] != b[31]) ? a[31] : (a < b);
    case (op)
      3'd1: return a == b;
      3'd2: return a != b;
      3'd3: return slt;
      3'd4: return !slt;
      3'd5: return a < b;
      3'd6: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic test_reset;
    exp_t e;
    reset  = 1'b1;
    ALUctl = {3'b010, 4'b0010};
    A      = 32'd5;
    B      = 32'd3;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (ALUOut !== 32'd0 || Branch_Enable !== 1'b0)
      $display("FAIL reset_init: got out=%h br=%b want out=0 br=0",
               ALUOut, Branch_Enable);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    e.out = 32'd8; e.br = 1'b1; e.name = "reset_release";
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    total++;
    if (ALUOut !== e.out || Branch_Enable !== e.br)
      $display("FAIL %s: got out=%h br=%b want out=%h br=%b",
               e.name, ALUOut, Branch_Enable, e.out, e.br);
    else passed++;
    // Reset asserted mid-stream discards the in-flight result.
    @(negedge clk);
    reset = 1'b1;
    A     = 32'd100;
    @(posedge clk);
    #1;
    total++;
    if (ALUOut !== 32'd0 || Branch_Enable !== 1'b0)
      $display("FAIL reset_mid: got out=%h br=%b want out=0 br=0",
               ALUOut, Branch_Enable);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_table(input int n);
    exp_t e;
    repeat (n) begin
      e = exp_q.pop_front();
      total++;
      if (ALUOut !== e.out)
        $display("FAIL %s out: got %h want %h", e.name, ALUOut, e.out);
      else passed++;
      total++;
      if (Branch_Enable !== e.br)
        $display("FAIL %s br: got %b want %b", e.name, Branch_Enable, e.br);
      else passed++;
    end
  endtask

  task automatic test_branch;
    drive({3'b001, 4'b0010}, 32'h0F, 32'h55, 32'h64, 1'b0, "beq"); check_table(1);
    drive({3'b010, 4'b0010}, 32'h0E, 32'h55, 32'h63, 1'b1, "bne"); check_table(1);
    drive({3'b011, 4'b0010}, 32'd10000, 32'd111, 32'd10111, 1'b0, "blt"); check_table(1);
    drive({3'b100, 4'b0010}, 32'd10000, 32'd111, 32'd10111, 1'b1, "bge"); check_table(1);
    drive({3'b101, 4'b0010}, 32'd0, 32'd2, 32'd2, 1'b1, "bltu"); check_table(1);
    drive({3'b110, 4'b0010}, 32'd16, 32'd2, 32'd18, 1'b1, "bgeu"); check_table(1);
    drive({3'b111, 4'b0000}, 32'd7, 32'd7, 32'd7, 1'b0, "br_rsvd"); check_table(1);
    drive({3'b000, 4'b0000}, 32'd7, 32'd7, 32'd7, 1'b0, "br_none"); check_table(1);
    drive({3'b100, 4'b0111}, 32'h80000000, 32'h7FFFFFFF, 32'd1, 1'b0, "bge_min"); check_table(1);
    drive({3'b110, 4'b1100}, 32'h80000000, 32'h7FFFFFFF, 32'd0, 1'b1, "bgeu_min"); check_table(1);
  endtask

  task automatic test_signed;
    drive({3'b011, 4'b0111}, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b1, "blt_slt"); check_table(1);
    drive({3'b101, 4'b1100}, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, "bltu_sltu"); check_table(1);
  endtask

  task automatic test_arith;
    drive({3'b000, 4'b0010}, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, "add_wrap"); check_table(1);
    drive({3'b000, 4'b0110}, 32'd0, 32'd1, 32'hFFFFFFFF, 1'b0, "sub_wrap"); check_table(1);
    drive({3'b000, 4'b0101}, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, "sra"); check_table(1);
    drive({3'b000, 4'b0011}, 32'h80000000, 32'd4, 32'h08000000, 1'b0, "srl"); check_table(1);
    drive({3'b000, 4'b0100}, 32'd1, 32'd31, 32'h80000000, 1'b0, "sll"); check_table(1);
    drive({3'b000, 4'b0100}, 32'h12345678, 32'h20, 32'h12345678, 1'b0, "sll0"); check_table(1);
    drive({3'b000, 4'b0101}, 32'h87654321, 32'hE0, 32'h87654321, 1'b0, "sra0"); check_table(1);
    drive({3'b000, 4'b0000}, 32'hF0F000FF, 32'h0FF00F0F, 32'h00F0000F, 1'b0, "and"); check_table(1);
    drive({3'b000, 4'b0001}, 32'hF0F000FF, 32'h0FF00F0F, 32'hFFF00FFF, 1'b0, "or"); check_table(1);
    drive({3'b000, 4'b1000}, 32'hF0F000FF, 32'h0FF00F0F, 32'hFF000FF0, 1'b0, "xor"); check_table(1);
    drive({3'b000, 4'b1111}, 32'hF0F000FF, 32'h0FF00F0F, 32'd0, 1'b0, "op_f"); check_table(1);
    drive({3'b000, 4'b1101}, 32'hF0F000FF, 32'h0FF00F0F, 32'd0, 1'b0, "op_d"); check_table(1);
  endtask

  task automatic test_csr;
`ifdef ALU_CSR_OPS_EN
    drive({3'b000, 4'b1011}, 32'h0F, 32'hFF, 32'hF0, 1'b0, "csrrc"); check_table(1);
    drive({3'b000, 4'b1001}, 32'h0F, 32'hFF, 32'h0F, 1'b0, "csrrw"); check_table(1);
    drive({3'b000, 4'b1010}, 32'h0F, 32'hF0, 32'hFF, 1'b0, "csrrs"); check_table(1);
`else
    drive({3'b000, 4'b1011}, 32'h0F, 32'hFF, 32'd0, 1'b0, "csrrc"); check_table(1);
    drive({3'b000, 4'b1001}, 32'h0F, 32'hFF, 32'd0, 1'b0, "csrrw"); check_table(1);
    drive({3'b000, 4'b1010}, 32'h0F, 32'hF0, 32'd0, 1'b0, "csrrs"); check_table(1);
`endif
  endtask

  task automatic test_latency;
    drive({3'b000, 4'b0010}, 32'd40, 32'd2, 32'd42, 1'b0, "lat_a"); check_table(1);
    @(negedge clk);
    ALUctl = {3'b001, 4'b0010};
    A      = 32'd9;
    B      = 32'd9;
    #1;
    total++;
    if (ALUOut !== 32'd42 || Branch_Enable !== 1'b0)
      $display("FAIL lat_hold: got out=%h br=%b want out=%h br=0",
               ALUOut, Branch_Enable, 32'd42);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (ALUOut !== 32'd18 || Branch_Enable !== 1'b1)
      $display("FAIL lat_b: got out=%h br=%b want out=%h br=1",
               ALUOut, Branch_Enable, 32'd18);
    else passed++;
  endtask

  task automatic test_back_to_back;
    logic [3:0] ops [10];
    logic [3:0] op;
    logic [2:0] bop;
    logic [31:0] a;
    logic [31:0] b;
    ops = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h8, 4'h4, 4'h3, 4'h5, 4'h7, 4'hC};
    for (int i = 0; i < 40; i++) begin
      op  = ops[$urandom_range(0, 9)];
      bop = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = (i % 4 == 0) ? a : $urandom;
      drive({bop, op}, a, b, ref_out(op, a, b), ref_br(bop, a, b), "b2b");
      check_table(1);
    end
  endtask

  initial begin
    total  = 0;
    passed = 0;
    reset  = 1'b1;
    ALUctl = '0;
    A      = '0;
    B      = '0;
    test_reset;
    test_branch;
    test_signed;
    test_arith;
    test_csr;
    test_latency;
    test_back_to_back;
    total++;
    if (exp_q.size() != 0)
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
